pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
Serialising controller for the team's bit-serial sequence detectors. It accepts parallel words over a valid/ready handshake and shifts them MSB-first as a continuous bit stream. The stream feeds an integrated, runtime-programmable, non-overlapping pattern matcher, which counts detections. It sits between a word-oriented producer (bus/FIFO) and the detection/status logic.

Parameters:
W, 8, input word width in bits (2..32)
CNT_W, 8, width of the saturating detection counter

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_we  in  1  configuration write strobe
cfg_pattern  in  8  pattern; only the low cfg_len bits are used, bit 0 is the last bit received
cfg_len  in  4  pattern length; 0 disables matching, 9..15 are clamped to 8
in_valid  in  1  producer has a word
in_data  in  W  word to scan
in_ready  out  1  controller accepts a word this cycle
busy  out  1  word being shifted
bit_out  out  1  current serial bit
bit_valid  out  1  bit_out is being consumed this cycle
det_pulse  out  1  one-cycle detection strobe
det_count  out  CNT_W  saturating detection count
clr_count  in  1  synchronous clear of det_count

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: state IDLE, shift register 0, bit counter 0, history and fill count 0, pattern 8'h0D, len 4, det_pulse 0, det_count 0, busy 0, bit_valid 0, bit_out 0. in_ready is 1 in the first cycle after reset.
- FSM states:
  - IDLE: in_ready=1, busy=0, bit_valid=0. On in_valid&in_ready, capture in_data, load bit counter with W-1, go to SHIFT.
  - SHIFT: busy=1, bit_valid=1, bit_out=shreg[W-1]. Each edge shifts left and decrements the counter.
  - in_ready = IDLE | (SHIFT & counter==0).
  - In the last SHIFT cycle with in_valid=1, the new word is loaded and the FSM stays in SHIFT with no bubble. Otherwise it returns to IDLE.
- Latency and throughput: word accepted at edge E0; bit i (0 = MSB) is valid in the cycle after edge Ei and consumed at edge E(i+1). Sustained throughput is W bits per W cycles.
- Matcher runs on every consumed bit:
  - hist <= {hist[6:0], bit}; fill <= min(fill+1, 8).
  - Match when len≠0, fill+1 ≥ len and the low len bits of the new hist equal the low len bits of cfg_pattern.
  - On match: hist and fill are cleared (non-overlapping); det_pulse=1 for exactly the cycle after the consuming edge; det_count increments at that edge, saturating at 2^CNT_W-1.
- History persists across word boundaries, so patterns spanning two words are detected whether the words are back-to-back or separated by idle gaps.
- Configuration: cfg_we is honoured only when the state is IDLE and no word is accepted in the same cycle; it is ignored otherwise. An honoured write loads pattern and clamped len and clears hist and fill. It does not change det_count.
- clr_count sets det_count to 0 and has priority over a simultaneous increment. det_pulse still fires.
- rst mid-SHIFT discards the word in flight; in_ready=1 in the next cycle.

Test Plan:
1. Assert rst for 2 cycles → in_ready=1, busy=0, bit_valid=0, det_pulse=0, det_count=0.
2. Default config, send 8'b11011011 → bits 1,1,0,1,1,0,1,1 on bit_out; one det_pulse, in the cycle after bit 4 is consumed; none at bit 7, because matches do not overlap; det_count=1.
3. Hold in_valid with 8'h01 then 8'hA0 → in_ready high only in cycle 8 of the first word; 16 contiguous bit_valid cycles; one detection of 1101 spanning the word boundary; det_count=1.
4. Pulse cfg_we with 8'h3C/len 8 during SHIFT, then with 8'hA5/len 8 in IDLE; send 8'hA5 → one det_pulse after bit 8. Send 8'h3C → none.
5. Parameter CNT_W=2, stream producing 5 matches → det_count sticks at 3. clr_count in a match cycle → det_count=0 and det_pulse=1.
6. rst asserted after bit 3 of a word; resend 8'b11010000 → no stale bits; one detection; det_count=1.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts parallel words over valid/ready, shifts them out
// MSB-first as a continuous bit stream and runs a programmable,
// non-overlapping pattern matcher with a saturating detection counter.
//
// Handshake: a word transfers on any rising edge where in_valid and in_ready
// are both high. in_ready depends only on internal state (never on in_valid),
// and a producer may hold in_valid/in_data until the transfer happens.
`timescale 1ns/1ps

module pattern_scan_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             det_pulse,
  output logic [CNT_W-1:0] det_count,
  input  logic             clr_count,
  output logic             dbg_state
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [7:0]       pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept;
  logic             cfg_ok;
  logic [7:0]       hist_shift;
  logic [3:0]       fill_inc;
  logic [7:0]       mask;
  logic             match;

  // Serialiser FSM: next state, shift register, bit counter and handshake outputs.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = CW'(W - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        bit_out   = shreg_q[W-1];
        if (cnt_q == '0) begin
          // Last bit of the word: chain the next word with no bubble.
          in_ready = 1'b1;
          if (in_valid) begin
            shreg_d = in_data;
            cnt_d   = CW'(W - 1);
          end else begin
            shreg_d = shreg_q << 1;
            state_d = S_IDLE;
          end
        end else begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;
  // Configuration only lands while idle and not racing a word acceptance.
  assign cfg_ok = cfg_we & (state_q == S_IDLE) & ~accept;

  // Matcher datapath: shifted history, fill count, compare mask and match flag.
  always_comb begin
    hist_shift = {hist_q[6:0], bit_out};
    fill_inc   = (fill_q >= 4'd8) ? 4'd8 : fill_q + 4'd1;
    for (int i = 0; i < 8; i++) begin
      mask[i] = (4'(i) < len_q);
    end
    match = bit_valid && (len_q != 4'd0) &&
            ({1'b0, fill_q} + 5'd1 >= {1'b0, len_q}) &&
            ((hist_shift & mask) == (pat_q & mask));
  end

  // Matcher/config/counter next-state: config write, history update, counting.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    pulse_d = 1'b0;
    count_d = count_q;
    if (cfg_ok) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > 4'd8) ? 4'd8 : cfg_len;
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      if (match) begin
        // Non-overlapping: a detection restarts the history from empty.
        hist_d  = '0;
        fill_d  = '0;
        pulse_d = 1'b1;
        if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + 1'b1;
        end
      end else begin
        hist_d = hist_shift;
        fill_d = fill_inc;
      end
    end
    if (clr_count) begin
      count_d = '0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= 8'h0D;
      len_q   <= 4'd4;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  assign det_pulse = pulse_q;
  assign det_count = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl. Inputs change and outputs are sampled
// 1ns after each rising edge; sample k of a transfer is taken after edge Ek,
// where E0 is the accepting edge.
`timescale 1ns/1ps

module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len = 4'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       clr_count = 1'b0;

  logic       in_ready, busy, bit_out, bit_valid, det_pulse, dbg_state;
  logic [7:0] det_count;
  logic       in_ready2, busy2, bit_out2, bit_valid2, det_pulse2, dbg_state2;
  logic [1:0] det_count2;

  int checks = 0;
  int errors = 0;

  // capture buffers, indexed by sample number
  logic [31:0] cap_bit, cap_bv, cap_pulse, cap_rdy, cap_busy;
  logic [1:0]  cap_cnt2 [0:31];
  int          cyc;

  pattern_scan_ctrl #(.W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .bit_out(bit_out), .bit_valid(bit_valid),
    .det_pulse(det_pulse), .det_count(det_count), .clr_count(clr_count),
    .dbg_state(dbg_state)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  pattern_scan_ctrl #(.W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .busy(busy2), .bit_out(bit_out2), .bit_valid(bit_valid2),
    .det_pulse(det_pulse2), .det_count(det_count2), .clr_count(clr_count),
    .dbg_state(dbg_state2)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (cyc < 32) begin
      cap_bit[cyc]   = bit_out;
      cap_bv[cyc]    = bit_valid;
      cap_pulse[cyc] = det_pulse;
      cap_rdy[cyc]   = in_ready;
      cap_busy[cyc]  = busy;
      cap_cnt2[cyc]  = det_count2;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    clr_count = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] p, input logic [3:0] l);
    cfg_pattern = p;
    cfg_len = l;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // Sends one word from IDLE and runs 9 samples (0..8). ev_kind selects a
  // strobe held for edge E(ev_at): 0 none, 1 cfg_we, 2 clr_count, 3 rst.
  task automatic send_word(input logic [7:0] w, input int ev_at, input int ev_kind);
    cyc = 0;
    cap_bit = '0; cap_bv = '0; cap_pulse = '0; cap_rdy = '0; cap_busy = '0;
    in_valid = 1'b1;
    in_data = w;
    for (int k = 0; k < 9; k++) begin
      if (k == ev_at) begin
        if (ev_kind == 1) cfg_we = 1'b1;
        if (ev_kind == 2) clr_count = 1'b1;
        if (ev_kind == 3) rst = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      cfg_we = 1'b0;
      clr_count = 1'b0;
      rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, busy, bit_valid, det_pulse, bit_out} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 10000", {in_ready, busy, bit_valid, det_pulse, bit_out});
    end
    checks++;
    if (det_count !== 8'd0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_count_state got count=%0d state=%b expected 0/0", det_count, dbg_state);
    end
  endtask

  task automatic test_single_word();
    do_reset();
    send_word(8'b11011011, -1, 0);
    checks++;
    if (cap_bit[8:0] !== 9'h0DB) begin
      errors++;
      $display("FAIL single_bits got %h expected 0db", cap_bit[8:0]);
    end
    checks++;
    if (cap_bv[8:0] !== 9'h0FF) begin
      errors++;
      $display("FAIL single_bit_valid got %h expected 0ff", cap_bv[8:0]);
    end
    checks++;
    if (cap_pulse[8:0] !== 9'h010) begin
      errors++;
      $display("FAIL single_pulse got %h expected 010", cap_pulse[8:0]);
    end
    checks++;
    if (cap_rdy[8:0] !== 9'h180) begin
      errors++;
      $display("FAIL single_ready got %h expected 180", cap_rdy[8:0]);
    end
    checks++;
    if (det_count !== 8'd1) begin
      errors++;
      $display("FAIL single_count got %0d expected 1", det_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc = 0;
    cap_bit = '0; cap_bv = '0; cap_pulse = '0; cap_rdy = '0; cap_busy = '0;
    in_valid = 1'b1;
    in_data = 8'h01;
    tick();
    in_data = 8'hA0;
    repeat (8) tick();
    in_valid = 1'b0;
    repeat (8) tick();
    checks++;
    if (cap_bv[16:0] !== 17'h0FFFF) begin
      errors++;
      $display("FAIL b2b_bit_valid got %h expected 0ffff", cap_bv[16:0]);
    end
    checks++;
    if (cap_rdy[16:0] !== 17'h18080) begin
      errors++;
      $display("FAIL b2b_ready got %h expected 18080", cap_rdy[16:0]);
    end
    checks++;
    if (cap_bit[16:0] !== 17'h00580) begin
      errors++;
      $display("FAIL b2b_bits got %h expected 00580", cap_bit[16:0]);
    end
    checks++;
    if (cap_pulse[16:0] !== 17'h00800) begin
      errors++;
      $display("FAIL b2b_pulse got %h expected 00800", cap_pulse[16:0]);
    end
    checks++;
    if (det_count !== 8'd1) begin
      errors++;
      $display("FAIL b2b_count got %0d expected 1", det_count);
    end
  endtask

  task automatic test_config();
    do_reset();
    // write during SHIFT must be dropped
    cfg_pattern = 8'h3C;
    cfg_len = 4'd8;
    send_word(8'h00, 3, 1);
    send_word(8'h3C, -1, 0);
    checks++;
    if (cap_pulse[8:0] !== 9'h000) begin
      errors++;
      $display("FAIL cfg_ignored_in_shift got %h expected 000", cap_pulse[8:0]);
    end
    // length 15 clamps to 8
    cfg_write(8'hA5, 4'd15);
    send_word(8'hA5, -1, 0);
    checks++;
    if (cap_pulse[8:0] !== 9'h100) begin
      errors++;
      $display("FAIL cfg_a5_pulse got %h expected 100", cap_pulse[8:0]);
    end
    send_word(8'h3C, -1, 0);
    checks++;
    if (cap_pulse[8:0] !== 9'h000) begin
      errors++;
      $display("FAIL cfg_3c_nomatch got %h expected 000", cap_pulse[8:0]);
    end
    // writes leave the count alone; len 0 disables matching
    cfg_write(8'h0D, 4'd0);
    send_word(8'hDD, -1, 0);
    checks++;
    if (cap_pulse[8:0] !== 9'h000 || det_count !== 8'd1) begin
      errors++;
      $display("FAIL cfg_disable got pulse=%h count=%0d expected 000/1", cap_pulse[8:0], det_count);
    end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    send_word(8'hDD, -1, 0);
    send_word(8'hDD, -1, 0);
    send_word(8'hD0, -1, 0);
    checks++;
    if (det_count !== 8'd5) begin
      errors++;
      $display("FAIL sat_wide_count got %0d expected 5", det_count);
    end
    checks++;
    if (det_count2 !== 2'd3) begin
      errors++;
      $display("FAIL sat_narrow_count got %0d expected 3", det_count2);
    end
    // clear coincides with the bit-3 match edge
    send_word(8'hDD, 4, 2);
    checks++;
    if (cap_pulse[4] !== 1'b1 || cap_cnt2[4] !== 2'd0 || cap_cnt2[3] !== 2'd3) begin
      errors++;
      $display("FAIL clr_in_match got pulse=%b cnt=%0d prev=%0d expected 1/0/3",
               cap_pulse[4], cap_cnt2[4], cap_cnt2[3]);
    end
    checks++;
    if (det_count !== 8'd1 || det_count2 !== 2'd1) begin
      errors++;
      $display("FAIL clr_after got %0d/%0d expected 1/1", det_count, det_count2);
    end
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    // bits 1,1,0 consumed, then reset on the edge that would consume bit 3
    send_word(8'hC0, 4, 3);
    checks++;
    if (cap_rdy[4] !== 1'b1 || cap_busy[4] !== 1'b0 || cap_bv[8:0] !== 9'h00F) begin
      errors++;
      $display("FAIL rst_mid got rdy=%b busy=%b bv=%h expected 1/0/00f",
               cap_rdy[4], cap_busy[4], cap_bv[8:0]);
    end
    send_word(8'b11010000, -1, 0);
    checks++;
    if (cap_bit[7:0] !== 8'h0B) begin
      errors++;
      $display("FAIL rst_resend_bits got %h expected 0b", cap_bit[7:0]);
    end
    checks++;
    if (cap_pulse[8:0] !== 9'h010 || det_count !== 8'd1) begin
      errors++;
      $display("FAIL rst_resend_det got pulse=%h count=%0d expected 010/1", cap_pulse[8:0], det_count);
    end
  endtask

  initial begin
    cyc = 0;
    #2;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_config();
    test_saturate_clear();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
